// File: rtl/sram_pkg.sv
// Shared types and geometry for the 1024 x 4 SRAM controller.
// Geometry: 64 rows x 64 bitline pairs, 16 column groups of 4 bits.
package sram_pkg;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 4;
    localparam int ROWS   = 64;
    localparam int COLS   = 64;
    localparam int ROW_W  = 6;
    localparam int COL_W  = 4;

    typedef enum logic [1:0] {
        IDLE,
        PRECHARGE,
        ACCESS,
        DONE
    } state_t;
endpackage

// File: rtl/sram_row_decoder.sv
// One-hot wordline decoder: 6-bit row plus active flag to 64 wordlines.
// Output is all-zero whenever the active flag is low.
module sram_row_decoder
    import sram_pkg::*;
(
    input  logic [ROW_W-1:0] i_row,
    input  logic             i_active,
    output logic [ROWS-1:0]  o_wordline
);
    always_comb begin
        o_wordline = '0;
        if (i_active) o_wordline[i_row] = 1'b1;
    end
endmodule

// File: rtl/sram_core.sv
// SRAM array controller: precharge / access / done sequencing.
// Define SRAM_CORE_ACCESS_STRETCH_EN to hold ACCESS for two cycles.
module sram_core
    import sram_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    input  logic              enable,
    input  logic              read_not_write,
    output logic [DATA_W-1:0] data_out,
    output logic              ready,
    output logic [ROWS-1:0]   wordline,
    output wire  [COLS-1:0]   bitline,
    output wire  [COLS-1:0]   bitline_bar,
    input  logic [COLS-1:0]   sense_data,
    output logic              precharge_en
);
    state_t             r_state;
    logic [ROW_W-1:0]   r_row;
    logic [COL_W-1:0]   r_col;
    logic [DATA_W-1:0]  r_data;
    logic               r_rnw;
    logic               r_wl_act;
    logic               r_drive;
    logic [DATA_W-1:0]  r_data_out;
    logic               r_ready;
    logic               r_pre;
    logic               w_acc_last;
    logic [DATA_W-1:0]  w_rd_slice;
    logic [COLS-1:0]    w_drv;

`ifdef SRAM_CORE_ACCESS_STRETCH_EN
    logic               r_hold;
    assign w_acc_last = r_hold;
`else
    assign w_acc_last = 1'b1;
`endif

    assign w_rd_slice = sense_data[{r_col, 2'b00} +: DATA_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_row      <= '0;
            r_col      <= '0;
            r_data     <= '0;
            r_rnw      <= 1'b0;
            r_wl_act   <= 1'b0;
            r_drive    <= 1'b0;
            r_data_out <= '0;
            r_ready    <= 1'b0;
            r_pre      <= 1'b0;
`ifdef SRAM_CORE_ACCESS_STRETCH_EN
            r_hold     <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (enable) begin
                        r_row   <= addr[ADDR_W-1:COL_W];
                        r_col   <= addr[COL_W-1:0];
                        r_data  <= data_in;
                        r_rnw   <= read_not_write;
                        r_pre   <= 1'b1;
                        r_state <= PRECHARGE;
                    end
                end
                PRECHARGE: begin
                    r_pre    <= 1'b0;
                    r_wl_act <= 1'b1;
                    r_drive  <= ~r_rnw;
                    r_state  <= ACCESS;
                end
                ACCESS: begin
`ifdef SRAM_CORE_ACCESS_STRETCH_EN
                    r_hold <= ~r_hold;
`endif
                    if (w_acc_last) begin
                        r_wl_act <= 1'b0;
                        r_drive  <= 1'b0;
                        r_ready  <= 1'b1;
                        r_state  <= DONE;
                        if (r_rnw) r_data_out <= w_rd_slice;
                    end
                end
                DONE: begin
                    r_ready <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    sram_row_decoder u_row_dec (
        .i_row      (r_row),
        .i_active   (r_wl_act),
        .o_wordline (wordline)
    );

    // Only the selected column group is driven; every other pair floats.
    for (genvar i = 0; i < COLS; i++) begin : g_bl
        assign w_drv[i]       = r_drive && (r_col == COL_W'(i / DATA_W));
        assign bitline[i]     = w_drv[i] ?  r_data[i % DATA_W] : 1'bz;
        assign bitline_bar[i] = w_drv[i] ? ~r_data[i % DATA_W] : 1'bz;
    end

    assign data_out     = r_data_out;
    assign ready        = r_ready;
    assign precharge_en = r_pre;
endmodule

// File: tb/tb_sram_core.sv
// Randomized bench for sram_core with a word-level reference memory.
// Bitlines are pulled low so an undriven pair reads as 00.
module tb_sram_core;
`ifdef SRAM_CORE_ACCESS_STRETCH_EN
    localparam int ACC = 2;
`else
    localparam int ACC = 1;
`endif
    localparam int PER = ACC + 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  addr;
    logic [3:0]  data_in;
    logic        enable;
    logic        read_not_write;
    logic [3:0]  data_out;
    logic        ready;
    logic [63:0] wordline;
    tri0  [63:0] bl;
    tri0  [63:0] blb;
    logic [63:0] sense_data;
    logic        precharge_en;

    int n_chk  = 0;
    int n_pass = 0;

    logic [3:0]  ref_mem [1024];
    logic [3:0]  ref_dout;
    logic [63:0] arr [64];

    always #5 clk = ~clk;

    sram_core dut (
        .clk            (clk),
        .rst            (rst),
        .addr           (addr),
        .data_in        (data_in),
        .enable         (enable),
        .read_not_write (read_not_write),
        .data_out       (data_out),
        .ready          (ready),
        .wordline       (wordline),
        .bitline        (bl),
        .bitline_bar    (blb),
        .sense_data     (sense_data),
        .precharge_en   (precharge_en)
    );

    // Behavioural bit-cell array stub
    always_comb begin
        sense_data = '0;
        for (int r = 0; r < 64; r++)
            if (wordline[r]) sense_data = arr[r];
    end

    always @(posedge clk) begin
        for (int r = 0; r < 64; r++)
            if (wordline[r])
                for (int b = 0; b < 64; b++)
                    if (bl[b] != blb[b]) arr[r][b] <= bl[b];
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_wl"}, wordline, 64'd0);
        chk({tag, "_pre"}, {63'd0, precharge_en}, 64'd0);
        chk({tag, "_bl"}, bl, 64'd0);
        chk({tag, "_blb"}, blb, 64'd0);
    endtask

    // Called at a negedge with the FSM in IDLE; returns at the next IDLE negedge.
    task automatic op(input bit rnw, input logic [9:0] a, input logic [3:0] d);
        int          row = int'(a[9:4]);
        int          col = int'(a[3:0]);
        logic [3:0]  nd  = ~d;
        logic [63:0] eb;
        logic [63:0] ebb;
        eb  = rnw ? 64'd0 : (64'(d)  << (col * 4));
        ebb = rnw ? 64'd0 : (64'(nd) << (col * 4));
        enable = 1'b1; read_not_write = rnw; addr = a; data_in = d;
        @(negedge clk);
        enable = 1'b0;
        addr = 10'($urandom); data_in = 4'($urandom);
        read_not_write = 1'($urandom);
        chk("pre_en", {63'd0, precharge_en}, 64'd1);
        chk("pre_wl", wordline, 64'd0);
        chk("pre_rdy", {63'd0, ready}, 64'd0);
        for (int c = 0; c < ACC; c++) begin
            @(negedge clk);
            chk("acc_wl", wordline, 64'd1 << row);
            chk("acc_pre", {63'd0, precharge_en}, 64'd0);
            chk("acc_bl", bl, eb);
            chk("acc_blb", blb, ebb);
            chk("acc_rdy", {63'd0, ready}, 64'd0);
        end
        if (rnw) ref_dout = ref_mem[a];
        else     ref_mem[a] = d;
        @(negedge clk);
        chk("done_rdy", {63'd0, ready}, 64'd1);
        chk("done_dout", {60'd0, data_out}, {60'd0, ref_dout});
        chk_idle("done");
        @(negedge clk);
        chk("idle_rdy", {63'd0, ready}, 64'd0);
        chk_idle("idle");
    endtask

    initial begin
        logic [9:0] a0;
        logic [9:0] a1;
        logic [3:0] d0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 4'd0;
        for (int r = 0; r < 64; r++) arr[r] = 64'd0;
        ref_dout = 4'd0;
        rst = 1'b1; enable = 1'b0; read_not_write = 1'b0;
        addr = '0; data_in = '0;
        repeat (2) @(negedge clk);
        chk("rst_dout", {60'd0, data_out}, 64'd0);
        chk("rst_rdy", {63'd0, ready}, 64'd0);
        chk_idle("rst");
        rst = 1'b0;
        @(negedge clk);

        op(1'b0, 10'h000, 4'hA);
        op(1'b1, 10'h000, 4'h0);
        op(1'b0, 10'h011, 4'h5);
        op(1'b0, 10'h012, 4'hC);
        op(1'b0, 10'h3FF, 4'h3);
        op(1'b1, 10'h011, 4'h0);
        op(1'b1, 10'h3FF, 4'h0);
        op(1'b1, 10'h010, 4'h0);
        op(1'b1, 10'h013, 4'h0);
        op(1'b1, 10'h012, 4'h0);
        op(1'b0, 10'h100, 4'h7);
        op(1'b1, 10'h100, 4'h0);

        // enable low: FSM must stay quiet
        for (int k = 0; k < 6; k++) begin
            addr = 10'($urandom); read_not_write = 1'($urandom);
            @(negedge clk);
            chk("noen_rdy", {63'd0, ready}, 64'd0);
            chk_idle("noen");
        end

        // enable held high: back-to-back reads, address changed mid-flight
        a0 = 10'h011; a1 = 10'h3FF;
        enable = 1'b1; read_not_write = 1'b1; addr = a0;
        for (int k = 1; k <= 2 * PER; k++) begin
            @(negedge clk);
            if (k == 1) addr = a1;
            if (k == 2 * PER) enable = 1'b0;
            chk("b2b_rdy", {63'd0, ready},
                {63'd0, (k == ACC + 2) || (k == ACC + 2 + PER)});
            chk("b2b_inv", {63'd0, precharge_en && (wordline != 0)}, 64'd0);
            if (k == ACC + 2) chk("b2b_d0", {60'd0, data_out}, {60'd0, ref_mem[a0]});
            if (k == ACC + 2 + PER) chk("b2b_d1", {60'd0, data_out}, {60'd0, ref_mem[a1]});
        end
        ref_dout = ref_mem[a1];
        @(negedge clk);
        chk("b2b_end", {63'd0, ready}, 64'd0);

        // async reset in the middle of a write ACCESS
        d0 = 4'hF;
        enable = 1'b1; read_not_write = 1'b0; addr = 10'h200; data_in = d0;
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_dout", {60'd0, data_out}, 64'd0);
        chk("arst_rdy", {63'd0, ready}, 64'd0);
        chk_idle("arst");
        ref_dout = 4'd0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        op(1'b1, 10'h200, 4'h0);

        for (int n = 0; n < 60; n++) begin
            logic [9:0] ra;
            ra = 10'($urandom_range(0, 31));
            if ($urandom_range(0, 1) == 1) ra = ra | 10'h3E0;
            op(1'($urandom), ra, 4'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
